// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU: opcodes, FSM states
// and the BCD digit correction constants.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ROR  = 4'b0000,
        OP_MUL  = 4'b0001,
        OP_ADD  = 4'b0011,
        OP_SUB  = 4'b0111,
        OP_ROL  = 4'b1011,
        OP_OR   = 4'b1100,
        OP_AND  = 4'b1101,
        OP_XOR  = 4'b1110,
        OP_PASS = 4'b1111
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        MUL   = 2'd2
    } state_t;

    localparam logic [3:0] BCD_CORR_ADD = 4'd6;
    localparam logic [3:0] BCD_CORR_SUB = 4'd10;

endpackage

// File: rtl/alu_seq_bcd_digit.sv
// One BCD digit step: decimal add (a+b+cin) or subtract (a-b-~cin)
// with decimal correction. Purely combinational; the top level feeds it one
// nibble per DIGIT cycle and keeps the running carry.
module bcd_digit
    import alu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] sum5;
    logic [4:0] diff5;

    // Digit add/sub; for subtract, cin=1 means "no borrow" from the lower digit
    always_comb begin
        sum5  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        diff5 = {1'b0, a} - {1'b0, b} - {4'b0, ~cin};
        d     = sum5[3:0];
        cout  = 1'b0;
        if (sub) begin
            if (diff5[4]) begin
                d    = diff5[3:0] + BCD_CORR_SUB;
                cout = 1'b0;
            end else begin
                d    = diff5[3:0];
                cout = 1'b1;
            end
        end else if (sum5 > 5'd9) begin
            d    = sum5[3:0] + BCD_CORR_ADD;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake. Binary and logic ops finish in
// one cycle; decimal ADD/SUB walks one BCD digit per enabled cycle; the
// optional unsigned shift-add multiplier is enabled by defining ALU_SEQ_MUL_EN.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = WIDTH / 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    input  logic             ci,
    input  logic             bcd,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             co,
    output logic             v,
    output logic             z,
    output logic             n,
    output logic             hc
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_sh_reg;
    logic             carry_reg, sub_reg, v_pend_reg, hc_bcd_reg;
    logic             out_valid_reg, co_reg, v_reg, z_reg, n_reg, hc_reg;
    logic [WIDTH-1:0] out_reg;

    logic [WIDTH-1:0] b_eff, bin_res, dig_res;
    logic [WIDTH:0]   sum_w;
    logic [4:0]       nib_sum;
    logic             add_v, bin_co, bin_v, bin_hc, start_bcd;
    logic [3:0]       dig_d;
    logic             dig_c;

    // Single-cycle result and flags straight from the request inputs
    always_comb begin
        b_eff     = (op == OP_SUB) ? ~bi : bi;
        sum_w     = {1'b0, ai} + {1'b0, b_eff} + {{WIDTH{1'b0}}, ci};
        nib_sum   = {1'b0, ai[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, ci};
        add_v     = (ai[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != ai[WIDTH-1]);
        start_bcd = ((op == OP_ADD) || (op == OP_SUB)) && bcd;
        bin_res   = ai;
        bin_co    = 1'b0;
        bin_v     = 1'b0;
        bin_hc    = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                bin_res = sum_w[WIDTH-1:0];
                bin_co  = sum_w[WIDTH];
                bin_v   = add_v;
                bin_hc  = nib_sum[4];
            end
            OP_ROL: begin
                bin_res = {ai[WIDTH-2:0], ci};
                bin_co  = ai[WIDTH-1];
            end
            OP_ROR: begin
                bin_res = {ci, ai[WIDTH-1:1]};
                bin_co  = ai[0];
            end
            OP_OR:   bin_res = ai | bi;
            OP_AND:  bin_res = ai & bi;
            OP_XOR:  bin_res = ai ^ bi;
            default: bin_res = ai;
        endcase
    end

    bcd_digit u_digit (
        .a    (a_sh_reg[3:0]),
        .b    (b_sh_reg[3:0]),
        .cin  (carry_reg),
        .sub  (sub_reg),
        .d    (dig_d),
        .cout (dig_c)
    );

    // New digit enters at the top so the result is aligned after the last digit
    assign dig_res = {dig_d, res_sh_reg[WIDTH-1:4]};

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mul_hi_reg, out_hi_reg, mul_hi_next, mul_lo_next;
    logic [WIDTH:0]   mul_sum;

    // One shift-add step: b_sh_reg doubles as the low product half
    always_comb begin
        mul_sum     = {1'b0, mul_hi_reg} + (b_sh_reg[0] ? {1'b0, a_sh_reg} : {(WIDTH+1){1'b0}});
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], b_sh_reg[WIDTH-1:1]};
    end

    assign out_hi = out_hi_reg;
`else
    assign out_hi = '0;
`endif

    // Sequencer FSM with registered result, flags and out_valid pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            res_sh_reg    <= '0;
            carry_reg     <= 1'b0;
            sub_reg       <= 1'b0;
            v_pend_reg    <= 1'b0;
            hc_bcd_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            co_reg        <= 1'b0;
            v_reg         <= 1'b0;
            z_reg         <= 1'b0;
            n_reg         <= 1'b0;
            hc_reg        <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mul_hi_reg    <= '0;
            out_hi_reg    <= '0;
`endif
        end else if (clk_en) begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (start_bcd) begin
                            state_reg  <= DIGIT;
                            cnt_reg    <= '0;
                            a_sh_reg   <= ai;
                            b_sh_reg   <= bi;
                            carry_reg  <= ci;
                            sub_reg    <= (op == OP_SUB);
                            v_pend_reg <= bin_v;
                        end
`ifdef ALU_SEQ_MUL_EN
                        else if (op == OP_MUL) begin
                            state_reg  <= MUL;
                            cnt_reg    <= '0;
                            a_sh_reg   <= ai;
                            b_sh_reg   <= bi;
                            mul_hi_reg <= '0;
                        end
`endif
                        else begin
                            out_valid_reg <= 1'b1;
                            out_reg       <= bin_res;
                            co_reg        <= bin_co;
                            v_reg         <= bin_v;
                            z_reg         <= (bin_res == '0);
                            n_reg         <= bin_res[WIDTH-1];
                            hc_reg        <= bin_hc;
`ifdef ALU_SEQ_MUL_EN
                            out_hi_reg    <= '0;
`endif
                        end
                    end
                end
                DIGIT: begin
                    a_sh_reg   <= a_sh_reg >> 4;
                    b_sh_reg   <= b_sh_reg >> 4;
                    res_sh_reg <= dig_res;
                    carry_reg  <= dig_c;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == '0) hc_bcd_reg <= dig_c;
                    if (cnt_reg == CW'(DIGITS - 1)) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b1;
                        out_reg       <= dig_res;
                        co_reg        <= dig_c;
                        v_reg         <= v_pend_reg;
                        z_reg         <= (dig_res == '0);
                        n_reg         <= dig_res[WIDTH-1];
                        hc_reg        <= hc_bcd_reg;
`ifdef ALU_SEQ_MUL_EN
                        out_hi_reg    <= '0;
`endif
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    mul_hi_reg <= mul_hi_next;
                    b_sh_reg   <= mul_lo_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b1;
                        out_reg       <= mul_lo_next;
                        out_hi_reg    <= mul_hi_next;
                        co_reg        <= 1'b0;
                        v_reg         <= 1'b0;
                        z_reg         <= ({mul_hi_next, mul_lo_next} == '0);
                        n_reg         <= mul_hi_next[WIDTH-1];
                        hc_reg        <= 1'b0;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign co        = co_reg;
    assign v         = v_reg;
    assign z         = z_reg;
    assign n         = n_reg;
    assign hc        = hc_reg;

endmodule
